// File: rtl/alarm_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : alarm_responder_if
// Description : Control/status bundle between an alarm detector front end
//               and the alarm_responder sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface alarm_responder_if #(
    parameter int CNT_W = 8
);
    logic             arm;
    logic             alarm_in;
    logic [4:0]       zones;
    logic             ack;
    logic             alarm_latched;
    logic             siren;
    logic [4:0]       zone_log;
    logic [CNT_W-1:0] event_count;
    logic             armed;

    // Drives arm/alarm/zones/ack and observes status
    modport master (
        output arm, alarm_in, zones, ack,
        input  alarm_latched, siren, zone_log, event_count, armed
    );

    // The responder itself
    modport slave (
        input  arm, alarm_in, zones, ack,
        output alarm_latched, siren, zone_log, event_count, armed
    );
endinterface
`default_nettype wire

// File: rtl/alarm_responder.sv
`default_nettype none
// ============================================================================
// Module      : alarm_responder
// Description : Debounces the raw 5-zone alarm, logs the triggering zone
//               pattern, counts qualified events (saturating), drives a
//               square-wave siren until acknowledged and re-arms after the
//               alarm input has stayed clear for the qualification window.
// Revision    : 1.0 - initial release
// ============================================================================
module alarm_responder #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int SIREN_PERIOD    = 8,
    parameter int CNT_W           = 8
) (
    input  wire               clk,
    input  wire               rst_n,
    alarm_responder_if.slave  bus
);

    // Debounce counters must hold values up to DEBOUNCE_CYCLES
    localparam int c_CW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int c_HALF = SIREN_PERIOD / 2;
    localparam int c_PW   = $clog2(c_HALF + 1);

    localparam logic [c_CW-1:0] c_DEB_LAST  = c_CW'(DEBOUNCE_CYCLES);
    localparam logic [c_PW-1:0] c_PH_LAST   = c_PW'(c_HALF - 1);
    localparam logic [CNT_W-1:0] c_CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        S_DISARMED = 3'd0,
        S_ARMED    = 3'd1,
        S_QUALIFY  = 3'd2,
        S_ALERT    = 3'd3,
        S_SILENCED = 3'd4
    } state_t;

    state_t           r_state;
    logic [c_CW-1:0]  r_qcnt;
    logic [c_CW-1:0]  r_ccnt;
    logic [c_PW-1:0]  r_phase;
    logic             r_siren;
    logic             r_alarm_latched;
    logic             r_armed;
    logic [4:0]       r_zone_log;
    logic [CNT_W-1:0] r_event_count;

    logic [c_CW-1:0]  w_qcnt_inc;
    logic [c_CW-1:0]  w_ccnt_inc;
    logic             w_qual_done;

    // Next counter values and the "this edge completes qualification" flag;
    // a single-cycle debounce lets ARMED jump straight to ALERT.
    always_comb begin
        w_qcnt_inc  = r_qcnt + c_CW'(1);
        w_ccnt_inc  = r_ccnt + c_CW'(1);
        w_qual_done = 1'b0;
        if (bus.alarm_in) begin
            if (r_state == S_ARMED && DEBOUNCE_CYCLES == 1)
                w_qual_done = 1'b1;
            else if (r_state == S_QUALIFY && w_qcnt_inc == c_DEB_LAST)
                w_qual_done = 1'b1;
        end
    end

    // Main sequencer: state, counters and all registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state         <= S_DISARMED;
            r_qcnt          <= '0;
            r_ccnt          <= '0;
            r_phase         <= '0;
            r_siren         <= 1'b0;
            r_alarm_latched <= 1'b0;
            r_armed         <= 1'b0;
            r_zone_log      <= '0;
            r_event_count   <= '0;
        end else if (!bus.arm) begin
            // Disarm clears activity but keeps the event history
            r_state         <= S_DISARMED;
            r_qcnt          <= '0;
            r_ccnt          <= '0;
            r_phase         <= '0;
            r_siren         <= 1'b0;
            r_alarm_latched <= 1'b0;
            r_armed         <= 1'b0;
        end else if (w_qual_done) begin
            // Qualified event: log, count, start the siren from phase 0
            r_state         <= S_ALERT;
            r_qcnt          <= '0;
            r_ccnt          <= '0;
            r_phase         <= '0;
            r_siren         <= 1'b1;
            r_alarm_latched <= 1'b1;
            r_armed         <= 1'b1;
            r_zone_log      <= bus.zones;
            if (r_event_count != c_CNT_MAX)
                r_event_count <= r_event_count + CNT_W'(1);
        end else begin
            case (r_state)
                S_DISARMED: begin
                    r_state <= S_ARMED;
                    r_armed <= 1'b1;
                end
                S_ARMED: begin
                    if (bus.alarm_in) begin
                        r_state <= S_QUALIFY;
                        r_qcnt  <= c_CW'(1);
                    end
                end
                S_QUALIFY: begin
                    if (bus.alarm_in) begin
                        r_qcnt <= w_qcnt_inc;
                    end else begin
                        r_state <= S_ARMED;
                        r_qcnt  <= '0;
                    end
                end
                S_ALERT: begin
                    if (bus.ack) begin
                        r_state <= S_SILENCED;
                        r_siren <= 1'b0;
                        r_phase <= '0;
                        r_ccnt  <= '0;
                    end else if (r_phase == c_PH_LAST) begin
                        r_phase <= '0;
                        r_siren <= ~r_siren;
                    end else begin
                        r_phase <= r_phase + c_PW'(1);
                    end
                end
                S_SILENCED: begin
                    // Re-arm only after a full window of clear samples
                    if (bus.alarm_in) begin
                        r_ccnt <= '0;
                    end else if (w_ccnt_inc == c_DEB_LAST) begin
                        r_state         <= S_ARMED;
                        r_ccnt          <= '0;
                        r_alarm_latched <= 1'b0;
                    end else begin
                        r_ccnt <= w_ccnt_inc;
                    end
                end
                default: begin
                    r_state         <= S_DISARMED;
                    r_qcnt          <= '0;
                    r_ccnt          <= '0;
                    r_phase         <= '0;
                    r_siren         <= 1'b0;
                    r_alarm_latched <= 1'b0;
                    r_armed         <= 1'b0;
                end
            endcase
        end
    end

    assign bus.alarm_latched = r_alarm_latched;
    assign bus.siren         = r_siren;
    assign bus.zone_log      = r_zone_log;
    assign bus.event_count   = r_event_count;
    assign bus.armed         = r_armed;

endmodule
`default_nettype wire
